dmem_arb: RTL and testbench

DMEM_ARB -- requirements
Module: dmem_arb

---
 rtl/dmem_arb_pkg.sv | 32 +++
 rtl/dmem_lane_align.sv | 63 ++++++
 rtl/dmem_arb.sv | 207 ++++++++++++++++++++
 tb/tb_dmem_arb.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the dmem_arb data-memory arbiter: FSM states,
// funct3 access-size codes, byte-enable patterns and the alignment check.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RESP
    } state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [3:0] BE_B = 4'b0001;
    localparam logic [3:0] BE_H = 4'b0011;
    localparam logic [3:0] BE_W = 4'b1111;

    // Legal size code and natural alignment for that size.
    function automatic logic acc_legal(input logic [2:0] size, input logic [1:0] lo);
        case (size)
            F3_B, F3_BU: acc_legal = 1'b1;
            F3_H, F3_HU: acc_legal = ~lo[0];
            F3_W:        acc_legal = (lo == 2'b00);
            default:     acc_legal = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational lane logic: store byte/half replication with byte enables,
// and load byte/half extraction with sign or zero extension.
module dmem_lane_align
    import dmem_arb_pkg::*;
(
    input  logic [2:0]  size,
    input  logic [1:0]  lo,
    input  logic [31:0] st_data,
    input  logic [31:0] ld_word,
    output logic [3:0]  be,
    output logic [31:0] st_lanes,
    output logic [31:0] ld_data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        case (lo)
            2'd0:    byte_sel = ld_word[7:0];
            2'd1:    byte_sel = ld_word[15:8];
            2'd2:    byte_sel = ld_word[23:16];
            default: byte_sel = ld_word[31:24];
        endcase
        // Offset 3 only occurs for unchecked misaligned halves: take the top byte.
        case (lo)
            2'd0:    half_sel = ld_word[15:0];
            2'd1:    half_sel = ld_word[23:8];
            2'd2:    half_sel = ld_word[31:16];
            default: half_sel = {8'h00, ld_word[31:24]};
        endcase
    end

    always_comb begin
        be       = BE_W;
        st_lanes = st_data;
        ld_data  = ld_word;
        case (size)
            F3_B: begin
                be       = BE_B << lo;
                st_lanes = {4{st_data[7:0]}};
                ld_data  = {{24{byte_sel[7]}}, byte_sel};
            end
            F3_BU: begin
                be       = BE_B << lo;
                st_lanes = {4{st_data[7:0]}};
                ld_data  = {24'h000000, byte_sel};
            end
            F3_H: begin
                be       = BE_H << lo;
                st_lanes = {2{st_data[15:0]}};
                ld_data  = {{16{half_sel[15]}}, half_sel};
            end
            F3_HU: begin
                be       = BE_H << lo;
                st_lanes = {2{st_data[15:0]}};
                ld_data  = {16'h0000, half_sel};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/dmem_arb.sv
// Two-requester round-robin data-memory arbiter with byte/half/word lanes.
// Define DMEM_ARB_ALIGN_CHK_EN to reject misaligned or illegal-size accesses.
module dmem_arb
    import dmem_arb_pkg::*;
#(
    parameter int unsigned MEM_LAT = 1
) (
    input  logic        clk,
    input  logic        res,
    input  logic        r0_req,
    input  logic        r0_we,
    input  logic [2:0]  r0_size,
    input  logic [31:0] r0_addr,
    input  logic [31:0] r0_wdata,
    output logic        r0_gnt,
    output logic        r0_done,
    output logic [31:0] r0_rdata,
    output logic        r0_err,
    input  logic        r1_req,
    input  logic        r1_we,
    input  logic [2:0]  r1_size,
    input  logic [31:0] r1_addr,
    input  logic [31:0] r1_wdata,
    output logic        r1_gnt,
    output logic        r1_done,
    output logic [31:0] r1_rdata,
    output logic        r1_err,
    output logic        m_en,
    output logic        m_we,
    output logic [3:0]  m_be,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    input  logic [31:0] m_rdata
);

    state_t      state;
    logic        owner;
    logic        last_gnt;
    logic        cur_we;
    logic [2:0]  cur_size;
    logic [1:0]  cur_lo;
    logic [1:0]  wcnt;

    logic        win;
    logic        sel_we;
    logic [2:0]  sel_size;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;
    logic        sel_ok;

    logic [2:0]  la_size;
    logic [1:0]  la_lo;
    logic [3:0]  la_be;
    logic [31:0] la_st;
    logic [31:0] la_ld;

    always_comb begin
        if (r0_req && r1_req) win = ~last_gnt;
        else                  win = r1_req;
        sel_we    = win ? r1_we    : r0_we;
        sel_size  = win ? r1_size  : r0_size;
        sel_addr  = win ? r1_addr  : r0_addr;
        sel_wdata = win ? r1_wdata : r0_wdata;
`ifdef DMEM_ARB_ALIGN_CHK_EN
        sel_ok    = acc_legal(sel_size, sel_addr[1:0]);
`else
        sel_ok    = 1'b1;
`endif
    end

    // One lane unit serves both directions: store lanes are registered on the
    // IDLE->ISSUE edge from the incoming request, load data from latched fields.
    assign la_size = (state == ST_IDLE) ? sel_size       : cur_size;
    assign la_lo   = (state == ST_IDLE) ? sel_addr[1:0]  : cur_lo;

    dmem_lane_align u_lane (
        .size     (la_size),
        .lo       (la_lo),
        .st_data  (sel_wdata),
        .ld_word  (m_rdata),
        .be       (la_be),
        .st_lanes (la_st),
        .ld_data  (la_ld)
    );

`ifndef DMEM_ARB_ALIGN_CHK_EN
    assign r0_err = 1'b0;
    assign r1_err = 1'b0;
`endif

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            state    <= ST_IDLE;
            owner    <= 1'b0;
            last_gnt <= 1'b1;
            cur_we   <= 1'b0;
            cur_size <= '0;
            cur_lo   <= '0;
            wcnt     <= '0;
            m_en     <= 1'b0;
            m_we     <= 1'b0;
            m_be     <= '0;
            m_addr   <= '0;
            m_wdata  <= '0;
            r0_gnt   <= 1'b0;
            r1_gnt   <= 1'b0;
            r0_done  <= 1'b0;
            r1_done  <= 1'b0;
            r0_rdata <= '0;
            r1_rdata <= '0;
`ifdef DMEM_ARB_ALIGN_CHK_EN
            r0_err   <= 1'b0;
            r1_err   <= 1'b0;
`endif
        end else begin
            m_en    <= 1'b0;
            m_we    <= 1'b0;
            m_be    <= '0;
            m_addr  <= '0;
            m_wdata <= '0;
            r0_gnt  <= 1'b0;
            r1_gnt  <= 1'b0;
            r0_done <= 1'b0;
            r1_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (r0_req || r1_req) begin
                        owner    <= win;
                        last_gnt <= win;
                        cur_we   <= sel_we;
                        cur_size <= sel_size;
                        cur_lo   <= sel_addr[1:0];
                        if (sel_ok) begin
                            state   <= ST_ISSUE;
                            m_en    <= 1'b1;
                            m_we    <= sel_we;
                            m_be    <= la_be;
                            m_addr  <= {sel_addr[31:2], 2'b00};
                            m_wdata <= sel_we ? la_st : '0;
                            r0_gnt  <= ~win;
                            r1_gnt  <= win;
                        end else begin
                            state <= ST_RESP;
                            if (win) begin
                                r1_done  <= 1'b1;
                                r1_rdata <= '0;
`ifdef DMEM_ARB_ALIGN_CHK_EN
                                r1_err   <= 1'b1;
`endif
                            end else begin
                                r0_done  <= 1'b1;
                                r0_rdata <= '0;
`ifdef DMEM_ARB_ALIGN_CHK_EN
                                r0_err   <= 1'b1;
`endif
                            end
                        end
                    end
                end
                ST_ISSUE: begin
                    if (cur_we) begin
                        state <= ST_RESP;
                        if (owner) begin
                            r1_done  <= 1'b1;
                            r1_rdata <= '0;
`ifdef DMEM_ARB_ALIGN_CHK_EN
                            r1_err   <= 1'b0;
`endif
                        end else begin
                            r0_done  <= 1'b1;
                            r0_rdata <= '0;
`ifdef DMEM_ARB_ALIGN_CHK_EN
                            r0_err   <= 1'b0;
`endif
                        end
                    end else begin
                        state <= ST_WAIT;
                        wcnt  <= 2'(MEM_LAT - 1);
                    end
                end
                ST_WAIT: begin
                    if (wcnt == 2'd0) begin
                        state <= ST_RESP;
                        if (owner) begin
                            r1_done  <= 1'b1;
                            r1_rdata <= la_ld;
`ifdef DMEM_ARB_ALIGN_CHK_EN
                            r1_err   <= 1'b0;
`endif
                        end else begin
                            r0_done  <= 1'b1;
                            r0_rdata <= la_ld;
`ifdef DMEM_ARB_ALIGN_CHK_EN
                            r0_err   <= 1'b0;
`endif
                        end
                    end else begin
                        wcnt <= wcnt - 2'd1;
                    end
                end
                ST_RESP: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_arb.sv
// Self-checking bench for dmem_arb (MEM_LAT=2): vector table plus arbitration
// and reset sequences, with a response scoreboard checked on each done pulse.
module tb_dmem_arb;

    localparam int LAT = 2;
`ifdef DMEM_ARB_ALIGN_CHK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        res;
    logic [1:0]  req, we, gnt, done, err;
    logic [2:0]  sz [2];
    logic [31:0] ad [2];
    logic [31:0] wd [2];
    logic [31:0] rd [2];
    logic        m_en, m_we;
    logic [3:0]  m_be;
    logic [31:0] m_addr, m_wdata, m_rdata;

    always #5 clk = ~clk;

    dmem_arb #(.MEM_LAT(LAT)) dut (
        .clk(clk), .res(res),
        .r0_req(req[0]), .r0_we(we[0]), .r0_size(sz[0]), .r0_addr(ad[0]), .r0_wdata(wd[0]),
        .r0_gnt(gnt[0]), .r0_done(done[0]), .r0_rdata(rd[0]), .r0_err(err[0]),
        .r1_req(req[1]), .r1_we(we[1]), .r1_size(sz[1]), .r1_addr(ad[1]), .r1_wdata(wd[1]),
        .r1_gnt(gnt[1]), .r1_done(done[1]), .r1_rdata(rd[1]), .r1_err(err[1]),
        .m_en(m_en), .m_we(m_we), .m_be(m_be), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_rdata(m_rdata)
    );

    typedef struct {
        int          who;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    typedef struct {
        int          who;
        logic        we;
        logic [2:0]  sz;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] mr;
        logic [3:0]  be;
        logic [31:0] mw;
        logic [31:0] rd;
        logic        err;
    } vec_t;

    exp_t        sb[$];
    vec_t        tbl[11];
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] prev_rd [2];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, want);
        end
    endtask

    // Scoreboard side: every done pulse must match the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        int   w;
        if (!res && (done != 2'b00)) begin
            check("done_onehot", {30'b0, done}, done[1] ? 32'd2 : 32'd1);
            w = done[1] ? 1 : 0;
            check("other_rdata_hold", rd[1-w], prev_rd[1-w]);
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_done: got done=%b expected none", done);
            end else begin
                e = sb.pop_front();
                check("done_who", w, e.who);
                check("rdata", rd[w], e.rdata);
                check("err", {31'b0, err[w]}, {31'b0, e.err});
            end
            prev_rd[w] = rd[w];
        end
    end

    task automatic access(input vec_t v);
        bit got;
        bit seen_men;
        int lat;
        int want_lat;
        sb.push_back('{v.who, v.rd, v.err});
        m_rdata   = v.mr;
        we[v.who] = v.we;
        sz[v.who] = v.sz;
        ad[v.who] = v.addr;
        wd[v.who] = v.wd;
        req[v.who] = 1'b1;
        got = 0;
        seen_men = 0;
        lat = 0;
        want_lat = v.err ? 1 : (v.we ? 2 : 2 + LAT);
        for (int k = 1; k <= 20 && !got; k++) begin
            @(negedge clk);
            if (m_en) seen_men = 1;
            if (gnt[v.who]) begin
                check("m_addr", m_addr, {v.addr[31:2], 2'b00});
                check("m_we", {31'b0, m_we}, {31'b0, v.we});
                if (v.we) begin
                    check("m_be", {28'b0, m_be}, {28'b0, v.be});
                    check("m_wdata", m_wdata, v.mw);
                end
                req[v.who] = 1'b0;
            end
            if (done[v.who]) begin
                got = 1;
                lat = k;
                req[v.who] = 1'b0;
            end
        end
        if (!got) begin
            n_cmp++;
            n_bad++;
            $display("FAIL done_timeout: got no done expected done in %0d cycles", want_lat);
            req[v.who] = 1'b0;
        end else begin
            check("latency", lat, want_lat);
        end
        check("m_en_seen", {31'b0, seen_men}, {31'b0, ~v.err});
        @(negedge clk);
    endtask

    initial begin
        int order[4];
        int ng;
        int r;
        bit got;
        res = 1'b1;
        req = '0; we = '0; m_rdata = '0;
        for (int i = 0; i < 2; i++) begin
            sz[i] = '0; ad[i] = '0; wd[i] = '0; prev_rd[i] = '0;
        end

        tbl[0]  = '{0, 1'b1, 3'b010, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0, 4'b1111, 32'hDEAD_BEEF, 32'h0, 1'b0};
        tbl[1]  = '{1, 1'b0, 3'b000, 32'h0000_0103, 32'h0, 32'h80FF_00AA, 4'b0000, 32'h0, 32'hFFFF_FF80, 1'b0};
        tbl[2]  = '{0, 1'b1, 3'b001, 32'h0000_0102, 32'h0000_1234, 32'h0, 4'b1100, 32'h1234_1234, 32'h0, 1'b0};
        tbl[3]  = '{1, 1'b1, 3'b000, 32'h0000_0101, 32'h0000_00A5, 32'h0, 4'b0010, 32'hA5A5_A5A5, 32'h0, 1'b0};
        tbl[4]  = '{0, 1'b0, 3'b100, 32'h0000_0102, 32'h0, 32'h80FF_00AA, 4'b0000, 32'h0, 32'h0000_00FF, 1'b0};
        tbl[5]  = '{1, 1'b0, 3'b001, 32'h0000_0102, 32'h0, 32'h80FF_00AA, 4'b0000, 32'h0, 32'hFFFF_80FF, 1'b0};
        tbl[6]  = '{0, 1'b0, 3'b101, 32'h0000_0000, 32'h0, 32'h80FF_00AA, 4'b0000, 32'h0, 32'h0000_00AA, 1'b0};
        tbl[7]  = '{1, 1'b0, 3'b010, 32'h0000_0204, 32'h0, 32'h1234_5678, 4'b0000, 32'h0, 32'h1234_5678, 1'b0};
        tbl[8]  = '{0, 1'b0, 3'b000, 32'h0000_0100, 32'h0, 32'h0000_007F, 4'b0000, 32'h0, 32'h0000_007F, 1'b0};
        tbl[9]  = '{0, 1'b0, 3'b010, 32'h0000_0101, 32'h0, 32'hA1B2_C3D4, 4'b0000, 32'h0,
                    CHK ? 32'h0 : 32'hA1B2_C3D4, CHK};
        tbl[10] = '{1, 1'b1, 3'b011, 32'h0000_0200, 32'hCAFE_F00D, 32'h0, 4'b1111, 32'hCAFE_F00D, 32'h0, CHK};

        @(negedge clk);
        check("rst_gnt", {30'b0, gnt}, 32'd0);
        check("rst_done", {30'b0, done}, 32'd0);
        check("rst_m_en", {31'b0, m_en}, 32'd0);
        check("rst_m_be", {28'b0, m_be}, 32'd0);
        check("rst_m_addr", m_addr, 32'd0);
        check("rst_rdata0", rd[0], 32'd0);
        check("rst_rdata1", rd[1], 32'd0);
        check("rst_err", {30'b0, err}, 32'd0);
        res = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 11; i++) access(tbl[i]);

        // Both requesting continuously from reset: grants must alternate.
        res = 1'b1;
        @(negedge clk);
        res = 1'b0;
        prev_rd[0] = '0; prev_rd[1] = '0;
        for (int i = 0; i < 2; i++) begin
            we[i] = 1'b1; sz[i] = 3'b010; ad[i] = 32'h400 + 32'(i * 4); wd[i] = 32'(i);
        end
        for (int i = 0; i < 4; i++) sb.push_back('{i % 2, 32'h0, 1'b0});
        req = 2'b11;
        ng = 0;
        for (int k = 0; k < 40 && ng < 4; k++) begin
            @(negedge clk);
            if (gnt != 2'b00) begin
                order[ng] = gnt[1] ? 1 : 0;
                ng++;
            end
        end
        req = 2'b00;
        if (ng < 4) begin
            n_cmp++;
            n_bad++;
            $display("FAIL rr_timeout: got %0d grants expected 4", ng);
        end
        for (int i = 0; i < ng; i++) check("rr_order", order[i], i % 2);
        repeat (4) @(negedge clk);

        // Reset pulsed mid-WAIT after an r0 load: no done, next tie goes to r0.
        sb.push_back('{0, 32'h0, 1'b0});
        sb.delete(sb.size() - 1);
        we[0] = 1'b0; sz[0] = 3'b010; ad[0] = 32'h300; m_rdata = 32'h5555_AAAA;
        req[0] = 1'b1;
        @(negedge clk);
        check("pre_rst_gnt", {31'b0, gnt[0]}, 32'd1);
        req[0] = 1'b0;
        @(negedge clk);
        #1 res = 1'b1;
        #2 res = 1'b0;
        prev_rd[0] = '0; prev_rd[1] = '0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("rst_mid_done", {30'b0, done}, 32'd0);
            check("rst_mid_m_en", {31'b0, m_en}, 32'd0);
        end
        for (int i = 0; i < 2; i++) begin
            we[i] = 1'b1; sz[i] = 3'b010; ad[i] = 32'h500; wd[i] = 32'h1;
        end
        sb.push_back('{0, 32'h0, 1'b0});
        req = 2'b11;
        got = 0;
        for (int k = 0; k < 10 && !got; k++) begin
            @(negedge clk);
            if (gnt != 2'b00) begin
                got = 1;
                check("tie_after_rst", {30'b0, gnt}, 32'd1);
                req = 2'b00;
            end
        end
        req = 2'b00;
        if (!got) begin
            n_cmp++;
            n_bad++;
            $display("FAIL tie_timeout: got no grant expected r0 grant");
        end
        repeat (4) @(negedge clk);

        r = sb.size();
        check("sb_drained", r, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
